// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - 4-digit 7-segment scan controller with inter-digit blanking
// Drives the nibble mux select, latches the returned nibble and emits registered anodes/segments.
module seg7_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       enable_i,
  input  logic [3:0] digit_mask_i,
  input  logic [3:0] dp_i,
  input  logic [3:0] nibble_i,
  output logic [1:0] sel_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_done_o
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             frame_done_q;
  logic [3:0]       nib_q;
  logic             dpl_q;
  logic [3:0]       show_an;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Mask is re-sampled every SHOW cycle so a digit can be blanked without waiting a frame.
  always_comb begin
    show_an = 4'hF;
    if (digit_mask_i[sel_q]) show_an = ~(4'b0001 << sel_q);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
      nib_q        <= 4'h0;
      dpl_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!enable_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        an_q    <= 4'hF;
        seg_q   <= 7'h7F;
        dp_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= BLANK;
            cnt_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
          end
          BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              nib_q   <= nibble_i;
              dpl_q   <= dp_i[sel_q];
              state_q <= SHOW;
              cnt_q   <= '0;
              an_q    <= show_an;
              seg_q   <= decode(nibble_i);
              dp_q    <= ~dp_i[sel_q];
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          SHOW: begin
            if (cnt_q == SHOW_LAST) begin
              sel_q        <= sel_q + 2'd1;
              state_q      <= BLANK;
              cnt_q        <= '0;
              an_q         <= 4'hF;
              seg_q        <= 7'h7F;
              dp_q         <= 1'b1;
              frame_done_q <= (sel_q == 2'd3);
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
              an_q  <= show_an;
              seg_q <= decode(nib_q);
              dp_q  <= ~dpl_q;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign sel_o        = sel_q;
  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;

endmodule
